// File: rtl/pc_sequencer_if.sv
// Single shared memory port of the Von Neumann machine: the sequencer drives the
// request (master) and the memory answers with a one-cycle ready (slave).
interface pc_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_ready;

   modport master (output mem_addr, output mem_rd, output mem_wr, input mem_ready);
   modport slave  (input mem_addr, input mem_rd, input mem_wr, output mem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/mem/exec sequencer: issues fetch and data accesses on the shared
// memory port, and produces the pc register's next value once per instruction.
module pc_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int WAIT_LIMIT = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] current_address_i,
   output logic [ADDR_W-1:0] next_address_o,
   pc_sequencer_if.master    mem,
   output logic              instr_load_o,
   input  logic              is_halt_i,
   input  logic              is_mem_op_i,
   input  logic              mem_is_write_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              halted_o,
   output logic              fault_o
);
   localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic               fault_q, fault_d;
   logic               at_limit;

   // Counter holds the number of cycles already waited; the limit is hit on the
   // WAIT_LIMIT-th request cycle that sees no ready.
   assign at_limit = (wait_q == CNT_W'(WAIT_LIMIT - 1));

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      fault_d = fault_q;
      case (state_q)
         S_FETCH, S_MEM: begin
            if (mem.mem_ready) begin
               state_d = (state_q == S_FETCH) ? S_DECODE : S_EXEC;
            end else if (at_limit) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            wait_d = '0;
            if (is_halt_i)        state_d = S_HALT;
            else if (is_mem_op_i) state_d = S_MEM;
            else                  state_d = S_EXEC;
         end
         S_EXEC: begin
            wait_d  = '0;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   // Outputs are forced to zero while reset is sampled so any request is abandoned at once.
   always_comb begin
      next_address_o = current_address_i;
      mem.mem_addr   = '0;
      mem.mem_rd     = 1'b0;
      mem.mem_wr     = 1'b0;
      instr_load_o   = 1'b0;
      if (reset_i) begin
         next_address_o = '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               mem.mem_addr = current_address_i;
               mem.mem_rd   = 1'b1;
               instr_load_o = mem.mem_ready;
            end
            S_MEM: begin
               mem.mem_addr = data_addr_i;
               mem.mem_wr   = mem_is_write_i;
               mem.mem_rd   = ~mem_is_write_i;
            end
            S_EXEC: begin
               next_address_o = branch_taken_i ? branch_target_i
                                               : current_address_i + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign halted_o = (state_q == S_HALT) && !reset_i;
   assign fault_o  = fault_q && !reset_i;
endmodule

// File: tb/tb_pc_sequencer.sv
// Instruction-level reference bench: each instruction is expanded into its expected
// per-cycle trace (fetch waits, decode, data waits, exec) and compared cycle by cycle.
module tb_pc_sequencer;
   localparam int WL = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] cur_addr = '0;
   logic [7:0] nxt_addr;
   logic       instr_load, halted, fault;
   logic       is_halt = 1'b0, is_mem_op = 1'b0, mem_is_write = 1'b0, branch_taken = 1'b0;
   logic [7:0] data_addr = '0, branch_target = '0;

   int         pass_cnt = 0;
   int         chk_cnt  = 0;

   logic [7:0] pc_m = '0;
   logic       fault_m = 1'b0;
   logic       halted_m = 1'b0;

   pc_sequencer_if #(.ADDR_W(8)) mif ();

   pc_sequencer #(.ADDR_W(8), .WAIT_LIMIT(WL)) dut (
      .clock_i           (clk),
      .reset_i           (rst),
      .current_address_i (cur_addr),
      .next_address_o    (nxt_addr),
      .mem               (mif.master),
      .instr_load_o      (instr_load),
      .is_halt_i         (is_halt),
      .is_mem_op_i       (is_mem_op),
      .mem_is_write_i    (mem_is_write),
      .data_addr_i       (data_addr),
      .branch_taken_i    (branch_taken),
      .branch_target_i   (branch_target),
      .halted_o          (halted),
      .fault_o           (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: apply inputs just after a posedge, check outputs 2ns later, then clock.
   task automatic step(input string ph, input logic rdy, input logic [7:0] e_next,
                       input logic e_chka, input logic [7:0] e_addr,
                       input logic e_rd, input logic e_wr, input logic e_il, input logic e_hlt);
      cur_addr      = pc_m;
      mif.mem_ready = rdy;
      #2;
      chk({ph, ".next"},   int'(nxt_addr),     int'(e_next));
      if (e_chka) chk({ph, ".addr"}, int'(mif.mem_addr), int'(e_addr));
      chk({ph, ".rd"},     int'(mif.mem_rd),   int'(e_rd));
      chk({ph, ".wr"},     int'(mif.mem_wr),   int'(e_wr));
      chk({ph, ".iload"},  int'(instr_load),   int'(e_il));
      chk({ph, ".halted"}, int'(halted),       int'(e_hlt));
      chk({ph, ".fault"},  int'(fault),        int'(fault_m));
      @(posedge clk);
      #1;
   endtask

   task automatic junk_decode();
      is_halt      = 1'($urandom);
      is_mem_op    = 1'($urandom);
      branch_taken = 1'($urandom);
      branch_target = 8'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fault_m = 1'b0;
      junk_decode();
      step("reset", 1'($urandom), 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      pc_m = 8'h00;
      halted_m = 1'b0;
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         junk_decode();
         step("halt", 1'($urandom), pc_m, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   // fw/dw: cycles without ready before ready arrives (>= WL means it never arrives).
   task automatic run_instr(input int fw, input int dw, input logic h, input logic m,
                            input logic w, input logic [7:0] da, input logic b,
                            input logic [7:0] tg);
      logic       rdy;
      logic [7:0] nxt;
      mem_is_write = w;
      data_addr    = da;
      for (int i = 0; ; i++) begin
         rdy = (i == fw);
         junk_decode();
         step("fetch", rdy, pc_m, 1'b1, pc_m, 1'b1, 1'b0, rdy, 1'b0);
         if (rdy) break;
         if (i == WL - 1) begin fault_m = 1'b1; halted_m = 1'b1; return; end
      end
      is_halt = h; is_mem_op = m; branch_taken = 1'($urandom);
      step("decode", 1'($urandom), pc_m, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (h) begin halted_m = 1'b1; return; end
      if (m) begin
         for (int i = 0; ; i++) begin
            rdy = (i == dw);
            junk_decode();
            step("mem", rdy, pc_m, 1'b1, da, !w, w, 1'b0, 1'b0);
            if (rdy) break;
            if (i == WL - 1) begin fault_m = 1'b1; halted_m = 1'b1; return; end
         end
      end
      is_halt = 1'($urandom); is_mem_op = 1'($urandom);
      branch_taken = b; branch_target = tg;
      nxt = b ? tg : 8'((int'(pc_m) + 1) % 256);
      step("exec", 1'($urandom), nxt, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      pc_m = nxt;
   endtask

   task automatic nop();
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic branch_to(input logic [7:0] t);
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, t);
   endtask

   initial begin
      mif.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset, then three zero-wait NOPs at 00, 01, 02.
      do_reset();
      nop(); nop(); nop();
      // Wrap from 0xFF to 0x00.
      branch_to(8'hFF);
      nop();
      nop();
      // Branch at 0x10 to 0x40.
      branch_to(8'h10);
      branch_to(8'h40);
      nop();
      // Store to 0x80 with 3 wait cycles; then boundary waits of WL-1 on both phases.
      run_instr(0, 3, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 8'h00);
      run_instr(WL - 1, WL - 1, 1'b0, 1'b1, 1'b0, 8'h21, 1'b0, 8'h00);
      // Fetch timeout: fault and halt with the PC unchanged.
      branch_to(8'h5A);
      run_instr(100, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      halt_cycles(3);
      do_reset();
      // Data-phase timeout.
      run_instr(0, 100, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 8'h00);
      halt_cycles(2);
      do_reset();
      // Reset in the middle of a store's data phase.
      branch_to(8'h33);
      mem_is_write = 1'b1; data_addr = 8'h80;
      junk_decode();
      step("fetch", 1'b1, pc_m, 1'b1, pc_m, 1'b1, 1'b0, 1'b1, 1'b0);
      is_halt = 1'b0; is_mem_op = 1'b1;
      step("decode", 1'b0, pc_m, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      junk_decode();
      step("mem", 1'b0, pc_m, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      nop();
      // Halt wins over a memory op.
      run_instr(0, 0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 8'h00);
      halt_cycles(5);
      do_reset();
      // Randomized instruction stream.
      for (int n = 0; n < 250; n++) begin
         int r1, r2, fw, dw;
         r1 = int'($urandom_range(0, 24));
         r2 = int'($urandom_range(0, 24));
         fw = (r1 == 0) ? 40 : (r1 == 1) ? WL - 1 : r1 % 4;
         dw = (r2 == 0) ? 40 : (r2 == 1) ? WL - 1 : r2 % 4;
         run_instr(fw, dw, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0),
                   1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
         if (halted_m) begin
            halt_cycles(int'($urandom_range(2, 4)));
            do_reset();
         end
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
